// File: rtl/dynamics_limiter_module.sv
// Per-sample dynamics limiter: attack/hold/release gain stage followed by a hard clip at the threshold.
// Optional gain monitor ports (current_gain, gain_reducing) are enabled by defining LIMITER_GAIN_MONITOR_EN.
module dynamics_limiter_module #(
    parameter int unsigned WIDTH        = 12,
    parameter int unsigned GAIN_FRAC    = 8,
    parameter int unsigned GAIN_MIN     = 64,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned HOLD_SAMPLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] incoming_sample,
    input  logic [1:0]              limiting_amount,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] modified_sample,
    output logic                    done
`ifdef LIMITER_GAIN_MONITOR_EN
    ,
    output logic [GAIN_FRAC:0]      current_gain,
    output logic                    gain_reducing
`endif
);

    localparam int unsigned GW = GAIN_FRAC + 1;
    localparam int unsigned PW = WIDTH + GAIN_FRAC + 1;
    localparam int unsigned HW = $clog2(HOLD_SAMPLES + 1);
    localparam int unsigned FS = 1 << (WIDTH - 1);
    localparam int unsigned T1 = (FS * 58) >> 6;
    localparam int unsigned T2 = (FS * 3) >> 2;
    localparam int unsigned T3 = FS >> 1;

    localparam logic [GW-1:0] UNITY  = GW'(1 << GAIN_FRAC);
    localparam logic [GW-1:0] MIN_V  = GW'(GAIN_MIN);
    localparam logic [GW-1:0] ATK_V  = GW'(ATTACK_STEP);
    localparam logic [GW-1:0] REL_V  = GW'(RELEASE_STEP);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD_SAMPLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MULT  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    logic [1:0]              state, state_nxt;
    logic signed [WIDTH-1:0] x_q;
    logic                    en_q;
    logic [1:0]              amt_q;
    logic signed [WIDTH:0]   y_q;
    logic [GW-1:0]           gain;
    logic [HW-1:0]           hold_q;

    logic signed [PW-1:0]    prod;
    logic signed [WIDTH:0]   y_c;
    logic signed [WIDTH:0]   thr;
    logic signed [WIDTH:0]   mag;
    logic                    bypass;
    logic                    overshoot;
    logic signed [WIDTH-1:0] out_c;
    logic [GW-1:0]           gain_nxt;
    logic [HW-1:0]           hold_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MULT;
            MULT:    state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        prod = PW'(x_q) * PW'($signed({1'b0, gain}));
        y_c  = (WIDTH + 1)'(prod >>> GAIN_FRAC);
    end

    always_comb begin
        thr = '0;
        case (amt_q)
            2'b01:   thr = (WIDTH + 1)'(T1);
            2'b10:   thr = (WIDTH + 1)'(T2);
            2'b11:   thr = (WIDTH + 1)'(T3);
            default: thr = '0;
        endcase
    end

    // Output selection and gain/hold update for the APPLY cycle.
    always_comb begin
        bypass    = !en_q || (amt_q == 2'b00);
        mag       = y_q[WIDTH] ? -y_q : y_q;
        overshoot = mag > thr;
        gain_nxt  = gain;
        hold_nxt  = hold_q;

        if (bypass)          out_c = x_q;
        else if (y_q > thr)  out_c = WIDTH'(thr);
        else if (y_q < -thr) out_c = WIDTH'(-thr);
        else                 out_c = WIDTH'(y_q);

        if (bypass) begin
            gain_nxt = UNITY;
            hold_nxt = '0;
        end else if (overshoot) begin
            gain_nxt = (gain >= MIN_V + ATK_V) ? gain - ATK_V : MIN_V;
            hold_nxt = HOLD_V;
        end else if (hold_q != '0) begin
            hold_nxt = hold_q - HW'(1);
        end else begin
            gain_nxt = (gain >= UNITY - REL_V) ? UNITY : gain + REL_V;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q             <= '0;
            en_q            <= 1'b0;
            amt_q           <= 2'b00;
            y_q             <= '0;
            modified_sample <= '0;
            done            <= 1'b0;
            gain            <= UNITY;
            hold_q          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q   <= incoming_sample;
                        en_q  <= enable;
                        amt_q <= limiting_amount;
                    end
                end
                MULT: y_q <= y_c;
                APPLY: begin
                    modified_sample <= out_c;
                    gain            <= gain_nxt;
                    hold_q          <= hold_nxt;
                    done            <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LIMITER_GAIN_MONITOR_EN
    assign current_gain = gain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)              gain_reducing <= 1'b0;
        else if (state == APPLY) gain_reducing <= gain_nxt < UNITY;
    end
`endif

endmodule
